uart_baud_gen: RTL

Parametrised UART bit-timing generator: a runtime-programmable fractional prescaler producing an oversampling strobe, a per-bit strobe and a mid-bit sample strobe. It replaces fixed-modulus baud counters. One instance feeds the TX serialiser, and a second instance, re-phased by `sync` on each start-bit edge, feeds the RX sampler.

---
 rtl/uart_baud_gen_pkg.sv | 15 +
 rtl/uart_frac_prescaler.sv | 62 ++++++
 rtl/uart_baud_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_pkg.sv
// Shared UART bit-timing constants and the divisor config bundle used by TX/RX blocks.
package uart_pkg;

   localparam int UART_DIV_W        = 16;
   localparam int UART_FRAC_W       = 4;
   localparam int UART_OSR          = 16;
   localparam int UART_DEFAULT_DIV  = 4;
   localparam int UART_DEFAULT_FRAC = 0;

   typedef struct packed {
      logic [UART_DIV_W-1:0]  div_int;
      logic [UART_FRAC_W-1:0] div_frac;
   } uart_div_t;

endpackage

// File: rtl/uart_frac_prescaler.sv
// Fractional prescaler: period = D + carry(acc + F); os_tick is registered one cycle ahead.
module uart_frac_prescaler #(
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_i,
   input  logic              tick_en_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic [FRAC_W-1:0] frac_i,
   input  logic [DIV_W-1:0]  div_nxt_i,
   input  logic [FRAC_W-1:0] frac_nxt_i,
   output logic              wrap_o,
   output logic              tick_nxt_o,
   output logic              os_tick_o
);

   logic [DIV_W-1:0]  pc_q, pc_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              os_tick_q;
   logic [FRAC_W:0]   sum, sum_nxt;
   logic [DIV_W:0]    per_m1, per_nxt_m1;

   always_comb begin
      sum    = {1'b0, acc_q} + {1'b0, frac_i};
      per_m1 = {1'b0, div_i} + (DIV_W+1)'(sum[FRAC_W]) - (DIV_W+1)'(1);
      wrap_o = run_i && ({1'b0, pc_q} >= per_m1);

      pc_d  = pc_q;
      acc_d = acc_q;
      if (!run_i) begin
         pc_d  = '0;
         acc_d = '0;
      end else if (wrap_o) begin
         pc_d  = '0;
         acc_d = sum[FRAC_W-1:0];
      end else begin
         pc_d  = pc_q + DIV_W'(1);
      end

      // Look ahead with the config that will be active next cycle so the tick can be a flop.
      sum_nxt    = {1'b0, acc_d} + {1'b0, frac_nxt_i};
      per_nxt_m1 = {1'b0, div_nxt_i} + (DIV_W+1)'(sum_nxt[FRAC_W]) - (DIV_W+1)'(1);
      tick_nxt_o = tick_en_i && ({1'b0, pc_d} == per_nxt_m1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         acc_q     <= '0;
         os_tick_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         acc_q     <= acc_d;
         os_tick_q <= tick_nxt_o;
      end
   end

   assign os_tick_o = os_tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART bit-timing generator: shadowed divisor config, oversample index and bit/mid-bit strobes.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W        = UART_DIV_W,
   parameter int FRAC_W       = UART_FRAC_W,
   parameter int OSR          = UART_OSR,
   parameter int DEFAULT_DIV  = UART_DEFAULT_DIV,
   parameter int DEFAULT_FRAC = UART_DEFAULT_FRAC
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    sync,
   input  logic                    cfg_load,
   input  logic [DIV_W-1:0]        div_int,
   input  logic [FRAC_W-1:0]       div_frac,
   output logic                    os_tick,
   output logic [$clog2(OSR)-1:0]  os_idx,
   output logic                    bit_tick,
   output logic                    mid_tick,
   output logic                    cfg_pending,
   output logic                    cfg_err
);

   localparam int IDX_W = $clog2(OSR);

   logic [DIV_W-1:0]  da_q, da_d, ds_q, ds_d;
   logic [FRAC_W-1:0] fa_q, fa_d, fs_q, fs_d;
   logic              pend_q, pend_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              bit_q, bit_d, mid_q, mid_d, err_q, err_d;
   logic              run, apply, tick_en, wrap, tick_nxt, os_tick_w;

   assign run = en && !sync && !err_q;

   always_comb begin
      da_d   = da_q;
      fa_d   = fa_q;
      ds_d   = ds_q;
      fs_d   = fs_q;
      pend_d = pend_q;
      // Idle (stopped, errored or restarting) generators take the shadow without waiting for a wrap.
      apply  = pend_q && (!run || wrap);

      if (cfg_load && sync) begin
         da_d   = div_int;
         fa_d   = div_frac;
         ds_d   = div_int;
         fs_d   = div_frac;
         pend_d = 1'b0;
      end else begin
         if (apply) begin
            da_d   = ds_q;
            fa_d   = fs_q;
            pend_d = 1'b0;
         end
         if (cfg_load) begin
            ds_d   = div_int;
            fs_d   = div_frac;
            pend_d = 1'b1;
         end
      end

      tick_en = en && (da_d != '0);
      err_d   = (da_d == '0);

      idx_d = idx_q;
      if (!run)
         idx_d = '0;
      else if (wrap)
         idx_d = (idx_q == IDX_W'(OSR-1)) ? '0 : idx_q + IDX_W'(1);

      bit_d = tick_nxt && (idx_d == IDX_W'(OSR-1));
      mid_d = tick_nxt && (idx_d == IDX_W'(OSR/2-1));
   end

   uart_frac_prescaler #(
      .DIV_W  (DIV_W),
      .FRAC_W (FRAC_W)
   ) u_presc (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_i      (run),
      .tick_en_i  (tick_en),
      .div_i      (da_q),
      .frac_i     (fa_q),
      .div_nxt_i  (da_d),
      .frac_nxt_i (fa_d),
      .wrap_o     (wrap),
      .tick_nxt_o (tick_nxt),
      .os_tick_o  (os_tick_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         da_q   <= DIV_W'(DEFAULT_DIV);
         fa_q   <= FRAC_W'(DEFAULT_FRAC);
         ds_q   <= DIV_W'(DEFAULT_DIV);
         fs_q   <= FRAC_W'(DEFAULT_FRAC);
         pend_q <= 1'b0;
         idx_q  <= '0;
         bit_q  <= 1'b0;
         mid_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         da_q   <= da_d;
         fa_q   <= fa_d;
         ds_q   <= ds_d;
         fs_q   <= fs_d;
         pend_q <= pend_d;
         idx_q  <= idx_d;
         bit_q  <= bit_d;
         mid_q  <= mid_d;
         err_q  <= err_d;
      end
   end

   assign os_tick     = os_tick_w;
   assign os_idx      = idx_q;
   assign bit_tick    = bit_q;
   assign mid_tick    = mid_q;
   assign cfg_pending = pend_q;
   assign cfg_err     = err_q;

endmodule
